// File: rtl/mux_stream_nx1_pkg.sv
// mux_stream_nx1_pkg: grant-mode constants and pointer helper shared by the stream mux slice.
package mux_stream_nx1_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int next_index(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mux_stream_nx1_rr_arbiter.sv
// mux_stream_nx1_rr_arbiter: picks the first requesting channel starting at ptr, wrapping modulo N_CH.
module mux_stream_nx1_rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            int k;
            k = int'(ptr) + i;
            k = (k >= N_CH) ? k - N_CH : k;
            if (!any && req[k]) begin
                any      = 1'b1;
                idx      = SEL_W'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stream_nx1.sv
// mux_stream_nx1: N:1 valid/ready stream mux with one registered output stage,
// granted either by an external select or by a round-robin arbiter.
module mux_stream_nx1
    import mux_stream_nx1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int MODE  = MODE_FIXED,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic                  load;
    logic                  g_any;
    logic                  xfer;
    logic [SEL_W-1:0]      g_idx;
    logic [SEL_W-1:0]      ptr;
    logic [N_CH-1:0]       onehot;
    logic [WIDTH-1:0]      words [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_word
        assign words[k] = in_data[k*WIDTH +: WIDTH];
    end

    if (MODE == MODE_RR) begin : g_rr
        logic unused_sel;
        assign unused_sel = ^sel;
        mux_stream_nx1_rr_arbiter #(
            .N_CH  (N_CH),
            .SEL_W (SEL_W)
        ) u_arb (
            .req   (in_valid),
            .ptr   (ptr),
            .grant (onehot),
            .idx   (g_idx),
            .any   (g_any)
        );
    end else begin : g_fixed
        // Select codes past the last channel (non power-of-two N_CH) grant nobody.
        logic [(1<<SEL_W)-1:0] sel_ok;
        logic                  unused_ptr;
        for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_ok
            assign sel_ok[i] = (i < N_CH);
        end
        assign unused_ptr = ^ptr;
        assign g_any  = sel_ok[sel];
        assign g_idx  = sel;
        assign onehot = g_any ? N_CH'(1) << sel : '0;
    end

    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !rst) ? onehot : '0;
    assign xfer     = g_any && load && in_valid[g_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= words[g_idx];
            out_ch    <= g_idx;
            ptr       <= SEL_W'(next_index(int'(g_idx), N_CH));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// tb_mux_stream_nx1: directed checks of fixed-select, round-robin and 3-channel variants.
module tb_mux_stream_nx1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] f_data;  logic [3:0] f_valid, f_ready; logic [1:0] f_sel, f_ch;
    logic [7:0]  f_odata; logic f_ovalid, f_oready;
    logic [31:0] r_data;  logic [3:0] r_valid, r_ready; logic [1:0] r_sel, r_ch;
    logic [7:0]  r_odata; logic r_ovalid, r_oready;
    logic [23:0] t_data;  logic [2:0] t_valid, t_ready; logic [1:0] t_sel, t_ch;
    logic [7:0]  t_odata; logic t_ovalid, t_oready;

    mux_stream_nx1 #(.WIDTH(8), .N_CH(4), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .sel(f_sel), .out_data(f_odata), .out_valid(f_ovalid), .out_ready(f_oready), .out_ch(f_ch));

    mux_stream_nx1 #(.WIDTH(8), .N_CH(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(r_data), .in_valid(r_valid), .in_ready(r_ready),
        .sel(r_sel), .out_data(r_odata), .out_valid(r_ovalid), .out_ready(r_oready), .out_ch(r_ch));

    mux_stream_nx1 #(.WIDTH(8), .N_CH(3), .MODE(0)) u_n3 (
        .clk(clk), .rst(rst), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
        .sel(t_sel), .out_data(t_odata), .out_valid(t_ovalid), .out_ready(t_oready), .out_ch(t_ch));

    task automatic test_reset();
        f_data = '0; f_valid = 4'hF; f_sel = 2'd0; f_oready = 1'b1;
        r_data = '0; r_valid = 4'hF; r_sel = 2'd0; r_oready = 1'b1;
        t_data = '0; t_valid = 3'h7; t_sel = 2'd0; t_oready = 1'b1;
        #1;
        checks++; if (f_ready !== 4'b0000) begin errors++; $display("FAIL reset_f_ready got %b want 0000", f_ready); end
        checks++; if (r_ready !== 4'b0000) begin errors++; $display("FAIL reset_r_ready got %b want 0000", r_ready); end
        checks++; if (f_ovalid !== 1'b0 || r_ovalid !== 1'b0 || t_ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b%b%b want 000", f_ovalid, r_ovalid, t_ovalid); end
        checks++; if (f_odata !== 8'h00 || f_ch !== 2'd0) begin errors++; $display("FAIL reset_fdata got %h/%0d want 00/0", f_odata, f_ch); end
        @(negedge clk);
        f_valid = '0; r_valid = '0; t_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        @(negedge clk);
        f_sel = 2'd2; f_valid = 4'b0100; f_data = 32'h00A5_0000; f_oready = 1'b1;
        #1;
        checks++; if (f_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b want 0100", f_ready); end
        @(negedge clk);
        checks++; if (f_ovalid !== 1'b1 || f_odata !== 8'hA5 || f_ch !== 2'd2) begin errors++; $display("FAIL fixed_out got v%b %h ch%0d want v1 a5 ch2", f_ovalid, f_odata, f_ch); end
        f_valid = 4'b0000;
        #1;
        checks++; if (f_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready_novalid got %b want 0100", f_ready); end
        @(negedge clk);
        checks++; if (f_ovalid !== 1'b0 || f_odata !== 8'hA5 || f_ch !== 2'd2) begin errors++; $display("FAIL fixed_drain got v%b %h ch%0d want v0 a5 ch2", f_ovalid, f_odata, f_ch); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        f_sel = 2'd1; f_valid = 4'b0010; f_data = 32'h0000_1100; f_oready = 1'b0;
        #1;
        checks++; if (f_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready_empty got %b want 0010", f_ready); end
        @(negedge clk);
        f_data = 32'h0000_2200;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (f_ovalid !== 1'b1 || f_odata !== 8'h11 || f_ch !== 2'd1) begin errors++; $display("FAIL bp_hold%0d got v%b %h ch%0d want v1 11 ch1", i, f_ovalid, f_odata, f_ch); end
            checks++; if (f_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready%0d got %b want 0000", i, f_ready); end
            if (i == 0) f_sel = 2'd3;
            if (i == 2) f_sel = 2'd1;
            @(negedge clk);
        end
        f_oready = 1'b1;
        #1;
        checks++; if (f_ready !== 4'b0010 || f_odata !== 8'h11) begin errors++; $display("FAIL bp_release got %b %h want 0010 11", f_ready, f_odata); end
        @(negedge clk);
        checks++; if (f_ovalid !== 1'b1 || f_odata !== 8'h22 || f_ch !== 2'd1) begin errors++; $display("FAIL bp_reload got v%b %h ch%0d want v1 22 ch1", f_ovalid, f_odata, f_ch); end
        f_valid = 4'b0000;
        @(negedge clk);
        checks++; if (f_ovalid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", f_ovalid); end
    endtask

    task automatic test_rr();
        logic [1:0] exp;
        @(negedge clk);
        r_valid = 4'hF; r_data = 32'h1312_1110; r_oready = 1'b1; r_sel = 2'd3;
        #1;
        checks++; if (r_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b want 0001", r_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp = 2'(i % 4);
            checks++; if (r_ovalid !== 1'b1 || r_ch !== exp || r_odata !== 8'h10 + 8'(exp)) begin errors++; $display("FAIL rr_seq%0d got v%b ch%0d %h want v1 ch%0d %h", i, r_ovalid, r_ch, r_odata, exp, 8'h10 + 8'(exp)); end
        end
        r_valid = 4'h0;
        #1;
        checks++; if (r_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready got %b want 0000", r_ready); end
        @(negedge clk);
        checks++; if (r_ovalid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", r_ovalid); end
    endtask

    task automatic test_sparse();
        logic [1:0] exp;
        logic [1:0] nxt;
        @(negedge clk);
        r_valid = 4'b1010; r_data = 32'h2300_2100;
        #1;
        checks++; if (r_ready !== 4'b0010) begin errors++; $display("FAIL sparse_first_ready got %b want 0010", r_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = (i % 2 == 1) ? 2'd3 : 2'd1;
            nxt = (exp == 2'd1) ? 2'd3 : 2'd1;
            checks++; if (r_ch !== exp || r_odata !== 8'h20 + 8'(exp)) begin errors++; $display("FAIL sparse_seq%0d got ch%0d %h want ch%0d %h", i, r_ch, r_odata, exp, 8'h20 + 8'(exp)); end
            #1;
            checks++; if (r_ready !== 4'(1 << nxt)) begin errors++; $display("FAIL sparse_ready%0d got %b want %b", i, r_ready, 4'(1 << nxt)); end
        end
        r_valid = 4'h0;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        t_sel = 2'd3; t_valid = 3'b111; t_data = 24'h33_2211; t_oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (t_ready !== 3'b000 || t_ovalid !== 1'b0) begin errors++; $display("FAIL oor%0d got ready %b v%b want 000 v0", i, t_ready, t_ovalid); end
            @(negedge clk);
        end
        t_sel = 2'd2;
        #1;
        checks++; if (t_ready !== 3'b100) begin errors++; $display("FAIL oor_sel2_ready got %b want 100", t_ready); end
        @(negedge clk);
        checks++; if (t_ovalid !== 1'b1 || t_odata !== 8'h33 || t_ch !== 2'd2) begin errors++; $display("FAIL oor_sel2_out got v%b %h ch%0d want v1 33 ch2", t_ovalid, t_odata, t_ch); end
        t_valid = 3'b000;
    endtask

    task automatic test_reset_midstall();
        @(negedge clk);
        f_sel = 2'd0; f_valid = 4'b0001; f_data = 32'h0000_005A; f_oready = 1'b0;
        @(negedge clk);
        checks++; if (f_ovalid !== 1'b1 || f_odata !== 8'h5A) begin errors++; $display("FAIL rst_pre got v%b %h want v1 5a", f_ovalid, f_odata); end
        #2;
        rst = 1'b1; f_oready = 1'b1;
        #1;
        checks++; if (f_ovalid !== 1'b0 || f_odata !== 8'h00 || f_ch !== 2'd0) begin errors++; $display("FAIL rst_async got v%b %h ch%0d want v0 00 ch0", f_ovalid, f_odata, f_ch); end
        checks++; if (f_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", f_ready); end
        @(negedge clk);
        rst = 1'b0; f_valid = 4'b0000;
        @(negedge clk);
        checks++; if (f_ovalid !== 1'b0) begin errors++; $display("FAIL rst_after got %b want 0", f_ovalid); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_rr();
        test_sparse();
        test_out_of_range();
        test_reset_midstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
